// File: rtl/bsg_idiv_pkg.sv
// Shared types and helpers for the iterative divider front-end and its consumers.
package bsg_idiv_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } bsg_idiv_op_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RES,
        RESP
    } bsg_idiv_issue_state_e;

    // DIV and REM are the signed flavours (op[0] clear)
    function automatic logic op_is_signed(input bsg_idiv_op_e op);
        return ~op[0];
    endfunction

    // REM and REMU return the remainder (op[1] set)
    function automatic logic op_is_rem(input bsg_idiv_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/bsg_idiv_op_decode.sv
// Combinational decode of a divider opcode into signed/remainder selects,
// plus a zero-divisor detect on the accompanying divisor.
module bsg_idiv_op_decode
    import bsg_idiv_pkg::*;
#(
    parameter int unsigned width_p = 32
) (
    input  logic [1:0]         op,
    input  logic [width_p-1:0] divisor,
    output logic               is_signed,
    output logic               is_rem,
    output logic               divisor_zero
);

    assign is_signed    = op_is_signed(bsg_idiv_op_e'(op));
    assign is_rem       = op_is_rem(bsg_idiv_op_e'(op));
    assign divisor_zero = (divisor == '0);

endmodule

// File: rtl/bsg_idiv_iterative_issue.sv
// Request front-end and result steering for the iterative integer divider.
// Holds one request at a time, issues it to the divider over valid/ready,
// consumes the quotient/remainder pair and returns the selected result with
// its tag over valid/yumi.
// Optional feature macro: BSG_IDIV_ZERO_FASTPATH_EN (zero-divisor bypass).
module bsg_idiv_iterative_issue
    import bsg_idiv_pkg::*;
#(
    parameter int unsigned width_p     = 32,
    parameter int unsigned tag_width_p = 5
) (
    input  logic                   clk_i,
    input  logic                   reset_i,

    input  logic                   v_i,
    output logic                   ready_and_o,
    input  logic [1:0]             op_i,
    input  logic [width_p-1:0]     dividend_i,
    input  logic [width_p-1:0]     divisor_i,
    input  logic [tag_width_p-1:0] tag_i,

    output logic                   div_v_o,
    input  logic                   div_ready_and_i,
    output logic [width_p-1:0]     div_dividend_o,
    output logic [width_p-1:0]     div_divisor_o,
    output logic                   div_signed_o,

    input  logic                   div_v_i,
    input  logic [width_p-1:0]     div_quotient_i,
    input  logic [width_p-1:0]     div_remainder_i,
    output logic                   div_yumi_o,

    output logic                   v_o,
    output logic [width_p-1:0]     result_o,
    output logic [tag_width_p-1:0] tag_o,
    input  logic                   yumi_i
);

`ifdef BSG_IDIV_ZERO_FASTPATH_EN
    localparam bit zero_fastpath = 1'b1;
`else
    localparam bit zero_fastpath = 1'b0;
`endif

    bsg_idiv_issue_state_e state, state_next;

    // Request register keeps the opcode in decoded form (signed/rem selects)
    logic                   req_signed;
    logic                   req_rem;
    logic [width_p-1:0]     req_dividend;
    logic [width_p-1:0]     req_divisor;
    logic [width_p-1:0]     result;
    logic [tag_width_p-1:0] tag;

    logic in_signed;
    logic in_rem;
    logic in_zero;
    logic accept;
    logic take_fast;
    logic take_result;

    bsg_idiv_op_decode #(
        .width_p(width_p)
    ) decode (
        .op          (op_i),
        .divisor     (divisor_i),
        .is_signed   (in_signed),
        .is_rem      (in_rem),
        .divisor_zero(in_zero)
    );

    assign accept      = v_i & ready_and_o;
    assign take_fast   = accept & zero_fastpath & in_zero;
    assign take_result = (state == WAIT_RES) & div_v_i;

    assign div_dividend_o = req_dividend;
    assign div_divisor_o  = req_divisor;
    assign result_o       = result;
    assign tag_o          = tag;

    // State register; reset forces IDLE immediately
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next   = state;
        ready_and_o  = 1'b0;
        div_v_o      = 1'b0;
        div_signed_o = 1'b0;
        div_yumi_o   = 1'b0;
        v_o          = 1'b0;
        unique case (state)
            IDLE: begin
                // state already reads IDLE during reset, so ready is masked explicitly
                ready_and_o = ~reset_i;
                if (v_i) begin
                    state_next = (zero_fastpath && in_zero) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                div_v_o      = 1'b1;
                div_signed_o = req_signed;
                if (div_ready_and_i) begin
                    state_next = WAIT_RES;
                end
            end
            WAIT_RES: begin
                div_yumi_o = div_v_i;
                if (div_v_i) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                v_o = 1'b1;
                if (yumi_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request, result and tag registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            req_signed   <= 1'b0;
            req_rem      <= 1'b0;
            req_dividend <= '0;
            req_divisor  <= '0;
            result       <= '0;
            tag          <= '0;
        end else begin
            if (accept) begin
                req_signed   <= in_signed;
                req_rem      <= in_rem;
                req_dividend <= dividend_i;
                req_divisor  <= divisor_i;
                tag          <= tag_i;
                if (take_fast) begin
                    result <= in_rem ? dividend_i : '1;
                end
            end
            if (take_result) begin
                result <= req_rem ? div_remainder_i : div_quotient_i;
            end
        end
    end

endmodule

// File: tb/tb_bsg_idiv_iterative_issue.sv
// Scoreboard bench for bsg_idiv_iterative_issue with a behavioural divider.
module tb_bsg_idiv_iterative_issue;
    import bsg_idiv_pkg::*;

    localparam int W  = 32;
    localparam int TW = 5;

`ifdef BSG_IDIV_ZERO_FASTPATH_EN
    localparam bit fast = 1'b1;
`else
    localparam bit fast = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_i;
    logic          v_i;
    logic          ready_and_o;
    logic [1:0]    op_i;
    logic [W-1:0]  dividend_i;
    logic [W-1:0]  divisor_i;
    logic [TW-1:0] tag_i;
    logic          div_v_o;
    logic          div_ready_and_i;
    logic [W-1:0]  div_dividend_o;
    logic [W-1:0]  div_divisor_o;
    logic          div_signed_o;
    logic          div_v_i;
    logic [W-1:0]  div_quotient_i;
    logic [W-1:0]  div_remainder_i;
    logic          div_yumi_o;
    logic          v_o;
    logic [W-1:0]  result_o;
    logic [TW-1:0] tag_o;
    logic          yumi_i;

    always #5 clk = ~clk;

    bsg_idiv_iterative_issue #(
        .width_p    (W),
        .tag_width_p(TW)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .v_i            (v_i),
        .ready_and_o    (ready_and_o),
        .op_i           (op_i),
        .dividend_i     (dividend_i),
        .divisor_i      (divisor_i),
        .tag_i          (tag_i),
        .div_v_o        (div_v_o),
        .div_ready_and_i(div_ready_and_i),
        .div_dividend_o (div_dividend_o),
        .div_divisor_o  (div_divisor_o),
        .div_signed_o   (div_signed_o),
        .div_v_i        (div_v_i),
        .div_quotient_i (div_quotient_i),
        .div_remainder_i(div_remainder_i),
        .div_yumi_o     (div_yumi_o),
        .v_o            (v_o),
        .result_o       (result_o),
        .tag_o          (tag_o),
        .yumi_i         (yumi_i)
    );

    typedef struct packed {
        logic [W-1:0]  result;
        logic [TW-1:0] tag;
    } resp_t;

    resp_t exp_q[$];
    int    checks     = 0;
    int    errors     = 0;
    int    issues     = 0;
    int    done_count = 0;
    int    hold       = 0;
    int    lat_force  = -1;
    bit    have       = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Divider arithmetic; a zero divisor yields distinctive markers so
    // pass-through is distinguishable from the front-end bypass
    function automatic logic [W-1:0] model_quot(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
        longint sa, sb, lo;
        if (b == '0) return a ^ 32'hDEAD_BEEF;
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            lo = sa / sb;
            return lo[W-1:0];
        end
        return a / b;
    endfunction

    function automatic logic [W-1:0] model_rem(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
        longint sa, sb, lo;
        if (b == '0) return a ^ 32'h0F0F_0F0F;
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            lo = sa % sb;
            return lo[W-1:0];
        end
        return a % b;
    endfunction

    function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit is_rem, sgn;
        is_rem = op[1];
        sgn    = ~op[0];
        if (fast && b == '0) return is_rem ? a : '1;
        return is_rem ? model_rem(a, b, sgn) : model_quot(a, b, sgn);
    endfunction

    // Behavioural divider: ready when idle, random latency, holds result until yumi
    initial begin
        int dstate;
        int lat;
        logic [W-1:0] q, r;
        dstate = 0;
        lat = 0;
        q = '0;
        r = '0;
        div_ready_and_i = 1'b1;
        div_v_i = 1'b0;
        div_quotient_i = '0;
        div_remainder_i = '0;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                dstate = 0;
                div_v_i = 1'b0;
                div_ready_and_i = 1'b1;
            end else begin
                case (dstate)
                    0: begin
                        div_v_i = 1'b0;
                        if (div_v_o) begin
                            issues++;
                            q = model_quot(div_dividend_o, div_divisor_o, div_signed_o);
                            r = model_rem(div_dividend_o, div_divisor_o, div_signed_o);
                            lat = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 4));
                            dstate = 1;
                        end else if (v_o && $urandom_range(0, 3) == 0) begin
                            div_v_i = 1'b1;
                            div_quotient_i = $urandom;
                            div_remainder_i = $urandom;
                            #1 check("spurious_div_yumi", div_yumi_o, 0);
                        end
                    end
                    1: begin
                        div_ready_and_i = 1'b0;
                        if (lat == 0) begin
                            div_v_i = 1'b1;
                            div_quotient_i = q;
                            div_remainder_i = r;
                            #1 check("div_yumi", div_yumi_o, 1);
                            dstate = 2;
                        end else begin
                            lat--;
                        end
                    end
                    default: begin
                        check("v_after_div_v", v_o, 1);
                        div_v_i = 1'b0;
                        div_ready_and_i = 1'b1;
                        dstate = 0;
                    end
                endcase
            end
        end
    end

    // Response monitor: pops the scoreboard when a response appears and
    // checks it stays stable while held
    initial begin
        resp_t cur;
        logic [W-1:0]  hr;
        logic [TW-1:0] ht;
        hr = '0;
        ht = '0;
        yumi_i = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                have = 1'b0;
                yumi_i = 1'b0;
            end else if (v_o) begin
                if (!have) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp actual=%h/%h required=none", result_o, tag_o);
                    end else begin
                        cur = exp_q.pop_front();
                        check("result", result_o, cur.result);
                        check("tag", tag_o, cur.tag);
                    end
                    have = 1'b1;
                    hr = result_o;
                    ht = tag_o;
                end else begin
                    check("result_hold", result_o, hr);
                    check("tag_hold", tag_o, ht);
                end
                check("ready_in_resp", ready_and_o, 0);
                check("div_v_in_resp", div_v_o, 0);
                if (hold > 0) begin
                    hold--;
                    yumi_i = 1'b0;
                end else begin
                    yumi_i = 1'($urandom_range(0, 1));
                end
                if (yumi_i) begin
                    have = 1'b0;
                    done_count++;
                end
            end else begin
                yumi_i = 1'b0;
            end
        end
    end

    // Issue one request (called at a negedge); optionally keep v_i high with
    // junk while it is outstanding, optionally wait for its response
    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] tag, input bit poke, input bit wait_done);
        int unsigned n;
        int iss0, target;
        bit zf;
        resp_t e;
        zf = fast && (b == '0);
        op_i = op;
        dividend_i = a;
        divisor_i = b;
        tag_i = tag;
        v_i = 1'b1;
        n = 0;
        while (!ready_and_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready_and_o) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=ready0 required=ready1");
            v_i = 1'b0;
            return;
        end
        e.result = ref_result(op, a, b);
        e.tag = tag;
        exp_q.push_back(e);
        iss0 = issues;
        target = done_count + 1;
        @(negedge clk);
        if (poke) begin
            op_i = 2'($urandom);
            dividend_i = $urandom;
            divisor_i = $urandom | 32'h1;
            tag_i = TW'($urandom);
        end else begin
            v_i = 1'b0;
        end
        if (zf) begin
            check("fast_v_next", v_o, 1);
            check("fast_no_div_v", div_v_o, 0);
        end else begin
            check("issue_v", div_v_o, 1);
            check("issue_signed", div_signed_o, {63'd0, ~op[0]});
            check("issue_dividend", div_dividend_o, a);
            check("issue_divisor", div_divisor_o, b);
        end
        if (!wait_done) return;
        n = 0;
        while (done_count < target && n < 300) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        v_i = 1'b0;
        if (done_count < target) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout actual=none required=response tag %0d", tag);
        end
        check("ready_after_yumi", ready_and_o, 1);
        check("issue_count", issues - iss0, zf ? 0 : 1);
    endtask

    // Directed cases, hold, reset mid-divide, then random traffic
    initial begin
        reset_i = 1'b1;
        v_i = 1'b0;
        op_i = '0;
        dividend_i = '0;
        divisor_i = '0;
        tag_i = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", ready_and_o, 0);
        check("rst_v", v_o, 0);
        check("rst_div_v", div_v_o, 0);
        check("rst_result", result_o, 0);
        check("rst_tag", tag_o, 0);
        check("rst_signed", div_signed_o, 0);
        reset_i = 1'b0;
        @(negedge clk);
        check("ready_after_reset", ready_and_o, 1);

        send(DIV,  32'd100,      32'd7,        5'd3, 1'b0, 1'b1);
        send(REM,  32'hFFFFFF9C, 32'd7,        5'd4, 1'b0, 1'b1);
        send(DIVU, 32'hFFFFFFFF, 32'd2,        5'd5, 1'b0, 1'b1);
        send(REMU, 32'hFFFFFFFF, 32'd2,        5'd6, 1'b0, 1'b1);
        send(DIV,  32'd5,        32'd0,        5'd7, 1'b0, 1'b1);
        send(REMU, 32'd5,        32'd0,        5'd8, 1'b0, 1'b1);
        send(DIV,  32'h80000000, 32'hFFFFFFFF, 5'd9, 1'b0, 1'b1);

        hold = 10;
        send(DIV, 32'd1000, 32'd10, 5'd10, 1'b1, 1'b1);

        lat_force = 10;
        send(DIV, 32'd77, 32'd7, 5'd11, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b1;
        #1;
        check("midrst_ready", ready_and_o, 0);
        check("midrst_div_v", div_v_o, 0);
        check("midrst_div_yumi", div_yumi_o, 0);
        check("midrst_v", v_o, 0);
        check("midrst_result", result_o, 0);
        check("midrst_tag", tag_o, 0);
        check("midrst_dividend", div_dividend_o, 0);
        check("midrst_divisor", div_divisor_o, 0);
        check("midrst_signed", div_signed_o, 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        lat_force = -1;
        @(negedge clk);
        check("ready_after_midrst", ready_and_o, 1);
        send(DIV, 32'd9, 32'd3, 5'd12, 1'b0, 1'b1);

        for (int unsigned i = 0; i < 60; i++) begin
            logic [1:0] op;
            logic [W-1:0] a, b;
            int unsigned k;
            op = 2'($urandom);
            a = $urandom;
            k = $urandom_range(0, 7);
            if (k == 0) b = '0;
            else if (k == 1) b = '1;
            else if (k == 2) b = W'($urandom_range(1, 15));
            else b = $urandom;
            send(op, a, b, TW'($urandom), ($urandom_range(0, 3) == 0), 1'b1);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
